// File: rtl/puf_race_controller_pkg.sv
// Shared definitions for the arbiter-PUF race controller: state encodings, counter widths, vote helper.
package puf_race_controller_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned ONES_W  = 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_FIRE  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_RELAX = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Strict majority of an odd number of votes.
   function automatic logic majority(input logic [ONES_W-1:0] ones,
                                     input logic [ONES_W-1:0] votes);
      return ones > (votes >> 1);
   endfunction

endpackage

// File: rtl/puf_race_controller_sync_2ff.sv
// Two-flop synchronizer for the asynchronous DFF-arbiter output; intentionally unreset.
module puf_race_controller_sync_2ff (
   input  logic clk,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic meta_q;
   (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic sync_q;

   always_ff @(posedge clk) begin
      meta_q <= d_i;
      sync_q <= meta_q;
   end

   assign q_o = sync_q;

endmodule

// File: rtl/puf_race_controller.sv
// Sequences one arbiter-PUF evaluation and majority-votes VOTE_COUNT races into a response bit.
// Optional PUF_UNSTABLE_FLAG_EN adds a non-unanimous (unstable) flag.
module puf_race_controller
   import puf_race_controller_pkg::*;
#(
   parameter int unsigned CHAL_WIDTH     = 64,
   parameter int unsigned PDL_WIDTH      = 8,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned CAPTURE_CYCLES = 4,
   parameter int unsigned VOTE_COUNT     = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [CHAL_WIDTH-1:0] challenge_i,
   input  logic [PDL_WIDTH-1:0]  pdl_cfg_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  response_o,
   output logic [ONES_W-1:0]     ones_count_o,
   output logic                  unstable_o,
   output logic [CHAL_WIDTH-1:0] puf_challenge_o,
   output logic [PDL_WIDTH-1:0]  puf_pdl_cfg_o,
   output logic                  puf_trigger_o,
   input  logic                  puf_arb_q_i
);

   localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CAPTURE_LAST = CNT_W'(CAPTURE_CYCLES - 1);
   localparam logic [ONES_W-1:0] VOTES        = ONES_W'(VOTE_COUNT);

   logic [STATE_W-1:0]    state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ONES_W-1:0]     votes_q, votes_d;
   logic [ONES_W-1:0]     ones_q, ones_d;
   logic [CHAL_WIDTH-1:0] chal_q, chal_d;
   logic [PDL_WIDTH-1:0]  pdl_q, pdl_d;
   logic                  resp_q, resp_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  trig_q, trig_d;
   logic                  unst_q, unst_d;
   logic                  arb_sync;

   puf_race_controller_sync_2ff u_sync (
      .clk (clk),
      .d_i (puf_arb_q_i),
      .q_o (arb_sync)
   );

   // Next-state, counters and registered-output lookahead.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      votes_d = votes_q;
      ones_d  = ones_q;
      chal_d  = chal_q;
      pdl_d   = pdl_q;
      resp_d  = resp_q;
      unst_d  = unst_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               chal_d  = challenge_i;
               pdl_d   = pdl_cfg_i;
               ones_d  = '0;
               votes_d = '0;
               resp_d  = 1'b0;
               unst_d  = 1'b0;
               cnt_d   = SETTLE_LAST;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cnt_q == '0) state_d = S_FIRE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_FIRE: begin
            cnt_d   = CAPTURE_LAST;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               if (arb_sync && (ones_q < VOTES)) ones_d = ones_q + ONES_W'(1);
               votes_d = votes_q + ONES_W'(1);
               cnt_d   = SETTLE_LAST;
               state_d = S_RELAX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RELAX: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (votes_q == VOTES) begin
               resp_d  = majority(ones_q, VOTES);
`ifdef PUF_UNSTABLE_FLAG_EN
               unst_d  = (ones_q != '0) && (ones_q != VOTES);
`endif
               state_d = S_DONE;
            end else begin
               state_d = S_FIRE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      trig_d = (state_d == S_FIRE) || (state_d == S_HOLD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         votes_q <= '0;
         ones_q  <= '0;
         chal_q  <= '0;
         pdl_q   <= '0;
         resp_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         trig_q  <= 1'b0;
         unst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         votes_q <= votes_d;
         ones_q  <= ones_d;
         chal_q  <= chal_d;
         pdl_q   <= pdl_d;
         resp_q  <= resp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         trig_q  <= trig_d;
         unst_q  <= unst_d;
      end
   end

   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign response_o      = resp_q;
   assign ones_count_o    = ones_q;
   assign unstable_o      = unst_q;
   assign puf_challenge_o = chal_q;
   assign puf_pdl_cfg_o   = pdl_q;
   assign puf_trigger_o   = trig_q;

endmodule
